// File: rtl/rd_cat_pkg.sv
// Shared constants and FSM encoding for the read concatenator.
package rd_cat_pkg;

  localparam int BURST_LEN   = 256;
  localparam int DEF_DATA_W  = 64;
  localparam int BURST_BYTES = BURST_LEN * DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_e;

  // Byte step between consecutive bursts for a given beat width.
  function automatic int burst_step(input int data_w);
    return BURST_LEN * data_w / 8;
  endfunction

endpackage

// File: rtl/rd_cat_fifo.sv
// Show-ahead synchronous FIFO standing in for the vendor FIFO IP.
module sync_fifo_wr #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             full, do_wr, do_rd;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];
  assign count   = cnt;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (srst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rd_cat.sv
// Splits a user read command into fixed-size AXI bursts, buffers the
// returned beats and streams them out with valid/ready.
module rd_cat
  import rd_cat_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH     = 1024
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        ddr_init_done,
  input  logic [AXI_ADDR_WIDTH+11:0]  user_rd_cmd,
  input  logic                        user_cmd_ren,
  output logic                        user_cmd_busy,
  output logic                        user_cmd_done,
  output logic                        rd_err,
  output logic                        rd_req_vld,
  input  logic                        rd_req_rdy,
  output logic [AXI_ADDR_WIDTH-1:0]   rd_req_addr,
  output logic [12:0]                 rd_req_length,
  input  logic                        rd_data_vld,
  input  logic [AXI_DATA_WIDTH-1:0]   rd_data,
  input  logic                        rd_data_last,
  output logic                        user_rd_vld,
  output logic [AXI_DATA_WIDTH-1:0]   user_rd_data,
  output logic                        user_rd_last,
  input  logic                        user_rd_rdy
);

  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int LEN_SH = $clog2(BURST_LEN);
  localparam int BW     = 12 - LEN_SH;
  localparam int FW     = AXI_DATA_WIDTH + 1;
  localparam int STEP   = burst_step(AXI_DATA_WIDTH);

  rd_state_e                 state, nxt;
  logic [AXI_ADDR_WIDTH-1:0] req_addr;
  logic [BW-1:0]             bursts_left, cmd_bursts;
  logic [CW-1:0]             outstanding, fifo_count;
  logic [CW:0]               used;
  logic                      fifo_empty, fifo_rd;
  logic [FW-1:0]             fifo_q;
  logic                      accept, req_hs, beat_ok, credit_ok, drained;
  logic                      out_vld, out_last;
  logic [AXI_DATA_WIDTH-1:0] out_data;
  logic                      unused_ok;

  assign cmd_bursts = user_rd_cmd[AXI_ADDR_WIDTH+11 : AXI_ADDR_WIDTH+LEN_SH];
  // Sub-burst length bits are deliberately ignored.
  assign unused_ok  = ^user_rd_cmd[AXI_ADDR_WIDTH+LEN_SH-1 : AXI_ADDR_WIDTH];

  assign accept    = (state == ST_IDLE) && user_cmd_ren && ddr_init_done;
  assign req_hs    = rd_req_vld && rd_req_rdy;
  // A beat nobody asked for is dropped rather than corrupting the FIFO.
  assign beat_ok   = rd_data_vld && (outstanding != '0);
  // Beats already in the FIFO plus beats still in flight must leave room
  // for one full burst, so the read channel never needs to stall.
  assign used      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok = used <= (CW+1)'(FIFO_DEPTH - BURST_LEN);
  assign drained   = (outstanding == '0) && fifo_empty;
  assign fifo_rd   = !fifo_empty && (!out_vld || user_rd_rdy);

  assign user_cmd_busy = (state != ST_IDLE);
  assign rd_req_addr   = req_addr;
  assign rd_req_length = 13'(BURST_LEN - 1);
  assign user_rd_vld   = out_vld;
  assign user_rd_data  = out_data;
  assign user_rd_last  = out_last;

  sync_fifo_wr #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .srst    (srst),
    .wr_en   (beat_ok),
    .wr_data ({rd_data_last, rd_data}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_q),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (srst) state <= ST_IDLE;
    else      state <= nxt;
  end

  // Next state, request valid and completion pulse.
  always_comb begin
    nxt           = state;
    rd_req_vld    = 1'b0;
    user_cmd_done = 1'b0;
    case (state)
      ST_IDLE:  if (accept && cmd_bursts != '0) nxt = ST_CHECK;
      ST_CHECK: if (credit_ok) nxt = ST_REQ;
      ST_REQ: begin
        rd_req_vld = 1'b1;
        if (rd_req_rdy) nxt = (bursts_left == BW'(1)) ? ST_DRAIN : ST_CHECK;
      end
      ST_DRAIN: begin
        // Everything received and only the output register left: its
        // handshake is the final beat of the command.
        if (drained && out_vld && user_rd_rdy) begin
          user_cmd_done = 1'b1;
          nxt           = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Address generator and remaining-burst counter.
  always_ff @(posedge clk) begin
    if (srst) begin
      req_addr    <= '0;
      bursts_left <= '0;
    end else if (accept) begin
      req_addr    <= user_rd_cmd[AXI_ADDR_WIDTH-1:0];
      bursts_left <= cmd_bursts;
    end else if (req_hs) begin
      req_addr    <= req_addr + AXI_ADDR_WIDTH'(STEP);
      bursts_left <= bursts_left - 1'b1;
    end
  end

  // In-flight beat count: a burst's worth on request, one off per beat.
  always_ff @(posedge clk) begin
    if (srst) outstanding <= '0;
    else      outstanding <= outstanding + (req_hs ? CW'(BURST_LEN) : '0)
                                         - (beat_ok ? CW'(1) : '0);
  end

  // Sticky error: zero-burst command or unsolicited beat.
  always_ff @(posedge clk) begin
    if (srst) rd_err <= 1'b0;
    else if ((accept && cmd_bursts == '0) || (rd_data_vld && outstanding == '0))
      rd_err <= 1'b1;
  end

  // Output register in front of the FIFO; holds while stalled.
  always_ff @(posedge clk) begin
    if (srst) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (fifo_rd) begin
      out_vld  <= 1'b1;
      out_last <= fifo_q[FW-1];
      out_data <= fifo_q[AXI_DATA_WIDTH-1:0];
    end else if (out_vld && user_rd_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rd_cat.sv
// Randomized scoreboard bench for rd_cat with an ADMA read responder model.
module tb_rd_cat;

  logic        clk = 1'b0;
  logic        srst;
  logic        ddr_init_done;
  logic [43:0] user_rd_cmd;
  logic        user_cmd_ren;
  logic        user_cmd_busy, user_cmd_done, rd_err;
  logic        rd_req_vld, rd_req_rdy;
  logic [31:0] rd_req_addr;
  logic [12:0] rd_req_length;
  logic        rd_data_vld, rd_data_last;
  logic [63:0] rd_data;
  logic        user_rd_vld, user_rd_last, user_rd_rdy;
  logic [63:0] user_rd_data;

  rd_cat dut (
    .clk(clk), .srst(srst), .ddr_init_done(ddr_init_done),
    .user_rd_cmd(user_rd_cmd), .user_cmd_ren(user_cmd_ren),
    .user_cmd_busy(user_cmd_busy), .user_cmd_done(user_cmd_done), .rd_err(rd_err),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_addr(rd_req_addr),
    .rd_req_length(rd_req_length), .rd_data_vld(rd_data_vld), .rd_data(rd_data),
    .rd_data_last(rd_data_last), .user_rd_vld(user_rd_vld), .user_rd_data(user_rd_data),
    .user_rd_last(user_rd_last), .user_rd_rdy(user_rd_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] data; logic last; logic done; } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] pend_q[$];
  int n_pass = 0, n_checks = 0;
  int n_req = 0, n_beats = 0, n_done = 0;
  int flush_req = 0, stray_req = 0, rdy_mode = 0;

  // Memory contents seen through the read channel.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: every whole 256-beat burst of the command, in address order.
  task automatic model_cmd(input logic [31:0] base, input int len);
    int nb;
    logic [31:0] a;
    nb = len / 256;
    for (int b = 0; b < nb; b++) begin
      a = base + 32'(b * 2048);
      exp_addr_q.push_back(a);
      for (int i = 0; i < 256; i++)
        exp_q.push_back('{data: mem_word(a + 32'(i * 8)), last: (i == 255),
                          done: (b == nb - 1) && (i == 255)});
    end
  endtask

  task automatic send_cmd(input logic [31:0] base, input int len);
    @(posedge clk); #1;
    user_rd_cmd  = {12'(len), base};
    user_cmd_ren = 1'b1;
    @(posedge clk); #1;
    user_cmd_ren = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || user_cmd_busy) && k < budget) begin
      @(negedge clk); k++;
    end
    n_checks++;
    if (k < budget) n_pass++;
    else $display("FAIL %s: timeout, %0d beats still expected", name, exp_q.size());
  endtask

  // User-side ready driver.
  initial begin
    user_rd_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       user_rd_rdy = 1'b0;
        1:       user_rd_rdy = 1'b1;
        default: user_rd_rdy = 1'($urandom_range(1));
      endcase
    end
  end

  // Request monitor: checks addresses and hands bursts to the responder.
  initial begin
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (!srst && rd_req_vld && rd_req_rdy) begin
        n_req++;
        check("req_length", 64'(rd_req_length), 64'h0ff);
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_req: got addr %h expected none", rd_req_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          check("req_addr", 64'(rd_req_addr), 64'(ea));
        end
        pend_q.push_back(rd_req_addr);
      end
    end
  end

  // ADMA read responder: returns requested bursts with random gaps.
  initial begin
    int ridx, flush_seen, stray_seen;
    ridx = 0; flush_seen = 0; stray_seen = 0;
    rd_data_vld = 1'b0; rd_data = '0; rd_data_last = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_data_vld  = 1'b0;
      rd_data_last = 1'b0;
      if (flush_seen != flush_req) begin
        flush_seen = flush_req;
        pend_q.delete();
        ridx = 0;
      end else if (stray_seen != stray_req) begin
        stray_seen++;
        rd_data_vld = 1'b1;
        rd_data     = {$urandom, $urandom};
      end else if (pend_q.size() > 0 && $urandom_range(3) != 0) begin
        rd_data_vld  = 1'b1;
        rd_data      = mem_word(pend_q[0] + 32'(ridx * 8));
        rd_data_last = (ridx == 255);
        ridx++;
        if (ridx == 256) begin
          void'(pend_q.pop_front());
          ridx = 0;
        end
      end
    end
  end

  // User-side monitor: pops the scoreboard on every handshake.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!srst && user_cmd_done) n_done++;
      if (!srst && user_rd_vld && user_rd_rdy) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_beat: got %h expected none", user_rd_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", user_rd_data, e.data);
          check("beat_last_done", 64'({user_rd_last, user_cmd_done}), 64'({e.last, e.done}));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, b0, d0, k;
    logic [31:0] a0, base;
    srst = 1'b1; ddr_init_done = 1'b0; user_rd_cmd = '0; user_cmd_ren = 1'b0; rd_req_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_user_vld", 64'(user_rd_vld), 0);
    check("rst_req_vld", 64'(rd_req_vld), 0);
    check("rst_busy", 64'(user_cmd_busy), 0);
    check("rst_err", 64'(rd_err), 0);
    check("rst_req_len", 64'(rd_req_length), 64'h0ff);

    // Strobe before init is ignored.
    send_cmd(32'h0, 256);
    repeat (4) @(negedge clk);
    check("preinit_busy", 64'(user_cmd_busy), 0);
    check("preinit_req", 64'(n_req), 0);
    ddr_init_done = 1'b1;

    // Two bursts from 0x1000, plus a strobe while busy that must be ignored.
    rdy_mode = 1; r0 = n_req; b0 = n_beats; d0 = n_done;
    model_cmd(32'h1000, 512);
    send_cmd(32'h1000, 512);
    @(negedge clk);
    check("t1_busy", 64'(user_cmd_busy), 1);
    send_cmd(32'h5000, 100);
    wait_idle("t1_idle", 5000);
    check("t1_reqs", 64'(n_req - r0), 2);
    check("t1_beats", 64'(n_beats - b0), 512);
    check("t1_done", 64'(n_done - d0), 1);
    check("t1_no_err", 64'(rd_err), 0);

    // Request held off for 5 clocks: valid/address stay put.
    rd_req_rdy = 1'b0; r0 = n_req;
    model_cmd(32'h0002_0000, 256);
    send_cmd(32'h0002_0000, 256);
    k = 0;
    while (!rd_req_vld && k < 20) begin @(negedge clk); k++; end
    check("t3_vld_seen", 64'(rd_req_vld), 1);
    a0 = rd_req_addr;
    repeat (5) begin
      @(negedge clk);
      check("t3_vld_hold", 64'(rd_req_vld), 1);
      check("t3_addr_hold", 64'(rd_req_addr), 64'(a0));
    end
    @(posedge clk); #1 rd_req_rdy = 1'b1;
    wait_idle("t3_idle", 5000);
    check("t3_reqs", 64'(n_req - r0), 1);

    // Random user ready, base near top of address space so bursts wrap.
    rdy_mode = 2;
    base = 32'hFFFF_F000 + 32'($urandom_range(255) * 8);
    model_cmd(base, 1024);
    send_cmd(base, 1024);
    wait_idle("t5a_idle", 20000);
    base = {$urandom} & 32'hFFFF_FFF8;
    k = $urandom_range(256, 2047);
    model_cmd(base, k);
    send_cmd(base, k);
    wait_idle("t5b_idle", 20000);

    // User stalled: only four bursts fit, then issue resumes.
    rdy_mode = 0; r0 = n_req; b0 = n_beats;
    base = {$urandom} & 32'hFFFF_FFF8;
    model_cmd(base, 4095);
    send_cmd(base, 4095);
    repeat (2500) @(negedge clk);
    check("t2_stalled_reqs", 64'(n_req - r0), 4);
    rdy_mode = 1;
    wait_idle("t2_idle", 30000);
    check("t2_reqs", 64'(n_req - r0), 15);
    check("t2_beats", 64'(n_beats - b0), 3840);

    // Zero-burst command: error, no request, never busy.
    r0 = n_req;
    send_cmd(32'h3000, 100);
    @(negedge clk);
    check("t4_busy", 64'(user_cmd_busy), 0);
    check("t4_err", 64'(rd_err), 1);
    repeat (4) @(negedge clk);
    check("t4_reqs", 64'(n_req - r0), 0);

    // Reset mid-command, stray beat, then a clean command.
    b0 = n_beats;
    model_cmd(32'h0010_0000, 1024);
    send_cmd(32'h0010_0000, 1024);
    k = 0;
    while (n_beats - b0 < 300 && k < 5000) begin @(negedge clk); k++; end
    check("t6_reach_300", 64'(n_beats - b0 >= 300), 1);
    @(posedge clk); #1;
    srst = 1'b1; rdy_mode = 0; flush_req++;
    exp_q.delete(); exp_addr_q.delete();
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk);
    check("t6_user_vld", 64'(user_rd_vld), 0);
    check("t6_user_data", user_rd_data, 0);
    check("t6_req_vld", 64'(rd_req_vld), 0);
    check("t6_busy", 64'(user_cmd_busy), 0);
    check("t6_err_clr", 64'(rd_err), 0);
    repeat (3) @(posedge clk);
    stray_req++;
    repeat (5) @(negedge clk);
    check("t6_stray_err", 64'(rd_err), 1);
    rdy_mode = 1; d0 = n_done; b0 = n_beats;
    model_cmd(32'h0000_8000, 256);
    send_cmd(32'h0000_8000, 256);
    wait_idle("t6_idle", 5000);
    check("t6_beats", 64'(n_beats - b0), 256);
    check("t6_done", 64'(n_done - d0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
